// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Brief    : Shared register map, CTRL bit positions and CTRL layout for the
//             multi-channel timer peripheral.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_PERIODIC  = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int CTRL_PRESC_LSB = 16;
    localparam int CTRL_PRESC_MSB = 31;

    typedef struct packed {
        logic [15:0] presc;
        logic [12:0] rsvd;
        logic        irq_en;
        logic        periodic;
        logic        en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/peri_timer_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : peri_timer_multi_if
//  Brief    : Word-addressed peripheral bus between the CPU side and the timer.
//  Revision : 1.0 - initial release
// ============================================================================
interface peri_timer_multi_if #(
    parameter int N_CH = 2
);
    localparam int ADDR_W = $clog2(N_CH) + 2;

    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output data,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  data,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module   : timer_channel
//  Brief    : One down-counting timer channel: prescaler, counter, reload,
//             CTRL, sticky EXP and optional level IRQ (macro TIMER_IRQ_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst,
    input  wire logic             wr_load_i,
    input  wire logic             wr_ctrl_i,
    input  wire logic             wr_status_i,
    input  wire logic [31:0]      wdata_i,
    output      ctrl_t            ctrl_o,
    output      logic [WIDTH-1:0] reload_o,
    output      logic [WIDTH-1:0] count_o,
    output      logic             exp_o,
    output      logic             irq_o
);

    ctrl_t            ctrl_q,   ctrl_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [15:0]      pcnt_q,   pcnt_d;
    logic             exp_q,    exp_d;
    logic             w_run;
    logic             w_expire;

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            pcnt_q   <= '0;
            exp_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            pcnt_q   <= pcnt_d;
            exp_q    <= exp_d;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        reload_d = reload_q;
        count_d  = count_q;
        pcnt_d   = pcnt_q;
        w_expire = 1'b0;
        // A CTRL write that clears EN freezes the channel on this very edge.
        w_run    = ctrl_q.en & ~(wr_ctrl_i & ~wdata_i[CTRL_EN]);

        if (wr_ctrl_i) begin
            ctrl_d          = '0;
            ctrl_d.en       = wdata_i[CTRL_EN];
            ctrl_d.periodic = wdata_i[CTRL_PERIODIC];
            ctrl_d.presc    = wdata_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
`ifdef TIMER_IRQ_EN
            ctrl_d.irq_en   = wdata_i[CTRL_IRQ_EN];
`endif
        end

        if (wr_load_i) begin
            reload_d = wdata_i[WIDTH-1:0];
            count_d  = wdata_i[WIDTH-1:0];
            pcnt_d   = ctrl_q.presc;
        end else if (w_run) begin
            if (pcnt_q == 16'd0) begin
                pcnt_d = ctrl_q.presc;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else if (count_q == WIDTH'(1)) begin
                    w_expire = 1'b1;
                    count_d  = ctrl_q.periodic ? reload_q : '0;
                end
            end else begin
                pcnt_d = pcnt_q - 16'd1;
            end
        end

        exp_d = (exp_q & ~(wr_status_i & wdata_i[0])) | w_expire;
    end

    assign ctrl_o   = ctrl_q;
    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign exp_o    = exp_q;

`ifdef TIMER_IRQ_EN
    assign irq_o = exp_q & ctrl_q.irq_en;
`else
    assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/peri_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : peri_timer_multi
//  Brief    : N_CH-channel timer peripheral: bus decode, channel array and
//             registered read mux. IRQ logic present only with TIMER_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module peri_timer_multi
    import timer_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int WIDTH = 32
) (
    input  wire logic            clk_i,
    input  wire logic            rst,
    peri_timer_multi_if.slave    bus,
    output      logic [N_CH-1:0] irq_o
);

    localparam int ADDR_W = $clog2(N_CH) + 2;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic             w_wr;
    logic             w_rd;
    ctrl_t            w_ctrl   [N_CH];
    logic [WIDTH-1:0] w_reload [N_CH];
    logic [WIDTH-1:0] w_count  [N_CH];
    logic [N_CH-1:0]  w_exp;
    logic [31:0]      rdata_d;
    logic [31:0]      rdata_q;

    assign w_reg = bus.addr[1:0];
    assign w_wr  = bus.sel &  bus.we;
    assign w_rd  = bus.sel & ~bus.we;

    if (N_CH > 1) begin : g_ch_dec
        assign w_ch = bus.addr[ADDR_W-1:2];
    end else begin : g_ch_single
        assign w_ch = 1'b0;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic w_hit;
        assign w_hit = w_wr & (w_ch == CH_W'(i));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk_i       (clk_i),
            .rst         (rst),
            .wr_load_i   (w_hit & (w_reg == REG_LOAD)),
            .wr_ctrl_i   (w_hit & (w_reg == REG_CTRL)),
            .wr_status_i (w_hit & (w_reg == REG_STATUS)),
            .wdata_i     (bus.data),
            .ctrl_o      (w_ctrl[i]),
            .reload_o    (w_reload[i]),
            .count_o     (w_count[i]),
            .exp_o       (w_exp[i]),
            .irq_o       (irq_o[i])
        );
    end

    // Channel indices beyond N_CH-1 decode to nothing and read back 0.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                case (w_reg)
                    REG_LOAD:   rdata_d[WIDTH-1:0] = w_reload[i];
                    REG_CTRL:   rdata_d            = w_ctrl[i];
                    REG_COUNT:  rdata_d[WIDTH-1:0] = w_count[i];
                    default:    rdata_d[0]         = w_exp[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (w_rd) begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_peri_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peri_timer_multi
//  Brief    : Directed self-checking bench for peri_timer_multi (N_CH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peri_timer_multi;

    localparam logic [2:0] A0_LOAD = 3'd0, A0_CTRL = 3'd1, A0_COUNT = 3'd2, A0_STAT = 3'd3;
    localparam logic [2:0] A1_LOAD = 3'd4, A1_CTRL = 3'd5, A1_COUNT = 3'd6, A1_STAT = 3'd7;

`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] irq;
    int         tests = 0;
    int         fails = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    peri_timer_multi_if #(.N_CH(2)) bus ();

    peri_timer_multi #(
        .N_CH  (2),
        .WIDTH (32)
    ) dut (
        .clk_i (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .irq_o (irq)
    );

    function automatic logic [31:0] mk_ctrl(input logic [15:0] p, input logic ie,
                                            input logic per, input logic en);
        return {p, 13'b0, ie, per, en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data = d;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(posedge clk); #1;
        bus.sel = 1'b0;
        d = bus.rdata;
    endtask

    task automatic rdchk(input logic [2:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Load every field with nonzero values, then reset mid-run
        wr(A1_CTRL, mk_ctrl(16'h1234, 1'b1, 1'b1, 1'b1));
        wr(A1_LOAD, 32'd100);
        wr(A0_CTRL, mk_ctrl(16'h0000, 1'b1, 1'b1, 1'b1));
        wr(A0_LOAD, 32'd1);
        rdchk(A1_CTRL, "ctrl_readback", mk_ctrl(16'h1234, IRQ_ON, 1'b1, 1'b1));
        rdchk(A1_LOAD, "load_readback", 32'd100);
        idle(2);
        chk("irq_pre_reset", {30'b0, irq}, {30'b0, 1'b0, IRQ_ON});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        chk("rdata_after_reset", bus.rdata, 32'h0);
        chk("irq_after_reset", {30'b0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) rdchk(3'(a), "reg_after_reset", 32'h0);

        // Ch0 one-shot, PRESC=0, LOAD=5 at edge E0
        wr(A0_CTRL, mk_ctrl(16'h0, 1'b0, 1'b0, 1'b1));
        wr(A0_LOAD, 32'd5);
        rdchk(A0_COUNT, "ch0_cnt5", 32'd5);
        rdchk(A0_COUNT, "ch0_cnt4", 32'd4);
        rdchk(A0_COUNT, "ch0_cnt3", 32'd3);
        rdchk(A0_COUNT, "ch0_cnt2", 32'd2);
        rdchk(A0_STAT,  "ch0_exp_before", 32'd0);
        rdchk(A0_STAT,  "ch0_exp_at5", 32'd1);
        rdchk(A0_COUNT, "ch0_cnt0", 32'd0);
        idle(5);
        rdchk(A0_COUNT, "ch0_cnt_stays0", 32'd0);
        chk("ch0_no_irq", {30'b0, irq}, 32'h0);

        // Ch1 periodic, PRESC=3, LOAD=2: expiries at E0+8 and E0+16
        wr(A1_CTRL, mk_ctrl(16'd3, 1'b1, 1'b1, 1'b1));
        wr(A1_LOAD, 32'd2);
        idle(7);
        chk("ch1_irq_e7", {31'b0, irq[1]}, 32'd0);
        idle(1);
        chk("ch1_irq_e8", {31'b0, irq[1]}, {31'b0, IRQ_ON});
        rdchk(A1_STAT, "ch1_exp_set", 32'd1);
        wr(A1_STAT, 32'd1);
        chk("ch1_irq_cleared", {31'b0, irq[1]}, 32'd0);
        rdchk(A1_STAT, "ch1_exp_cleared", 32'd0);
        idle(4);
        chk("ch1_irq_e15", {31'b0, irq[1]}, 32'd0);
        idle(1);
        chk("ch1_irq_e16", {31'b0, irq[1]}, {31'b0, IRQ_ON});
        rdchk(A1_STAT, "ch1_exp_again", 32'd1);
        wr(A1_CTRL, 32'd0);
        wr(A1_STAT, 32'd1);

        // LOAD=0 never expires
        wr(A0_STAT, 32'd1);
        wr(A0_LOAD, 32'd0);
        idle(100);
        rdchk(A0_STAT,  "load0_exp", 32'd0);
        rdchk(A0_COUNT, "load0_cnt", 32'd0);

        // W1C on the expiry edge: set wins
        wr(A0_LOAD, 32'd3);
        idle(2);
        wr(A0_STAT, 32'd1);
        rdchk(A0_STAT, "w1c_vs_set", 32'd1);
        wr(A0_STAT, 32'd1);
        rdchk(A0_STAT, "w1c_clears", 32'd0);

        // LOAD write on a tick edge: write wins, no decrement
        wr(A0_CTRL, mk_ctrl(16'd2, 1'b0, 1'b0, 1'b1));
        wr(A0_LOAD, 32'd10);
        idle(2);
        wr(A0_LOAD, 32'd20);
        rdchk(A0_COUNT, "load_on_tick_a", 32'd20);
        rdchk(A0_COUNT, "load_on_tick_b", 32'd20);
        rdchk(A0_COUNT, "load_on_tick_c", 32'd20);
        rdchk(A0_COUNT, "load_on_tick_d", 32'd19);

        // Pause at COUNT=7 with pcnt=2 held, then resume
        wr(A0_CTRL, mk_ctrl(16'd3, 1'b0, 1'b0, 1'b1));
        wr(A0_LOAD, 32'd9);
        idle(9);
        wr(A0_CTRL, mk_ctrl(16'd3, 1'b0, 1'b0, 1'b0));
        idle(10);
        rdchk(A0_COUNT, "hold_cnt7", 32'd7);
        wr(A0_CTRL, mk_ctrl(16'd3, 1'b0, 1'b0, 1'b1));
        idle(2);
        rdchk(A0_COUNT, "resume_pre", 32'd7);
        rdchk(A0_COUNT, "resume_tick", 32'd6);

        // Clearing EN on a tick edge discards the tick
        idle(2);
        wr(A0_CTRL, mk_ctrl(16'd3, 1'b0, 1'b0, 1'b0));
        rdchk(A0_COUNT, "disable_on_tick", 32'd6);
        chk("irq_final", {30'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
